// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: drives an external LFSR and packs its serial output MSB-first into words,
// with valid/ready backpressure that stalls the LFSR instead of dropping bits.
module lfsr_seq_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  nbits,
  input  logic              reseed,
  input  logic              abort,
  output logic              lfsr_ld,
  output logic              lfsr_en,
  input  logic              lfsr_dout,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);
  localparam int NW = $clog2(WORD_W + 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, STALL, FLUSH} state_t;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pk_q, pk_d, word_q, word_d, pk_sh;
  logic [NW-1:0]     pn_q, pn_d, pn_inc;
  logic              valid_q, valid_d, done_d, ld_q, en_q, busy_q, done_q;
  logic              last, full;
  always_comb begin
    pk_sh   = {pk_q[WORD_W-2:0], lfsr_dout};
    pn_inc  = pn_q + 1'b1;
    last    = cnt_q == CNT_W'(1);
    full    = pn_inc == NW'(WORD_W);
    state_d = state_q;
    cnt_d   = cnt_q;
    pk_d    = pk_q;
    pn_d    = pn_q;
    word_d  = word_q;
    valid_d = valid_q && !word_ready;
    done_d  = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      pk_d    = '0;
      pn_d    = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (start && !abort) begin
            if (nbits == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = nbits;
              pk_d    = '0;
              pn_d    = '0;
              state_d = reseed ? LOAD : RUN;
            end
          end
        LOAD: state_d = RUN;
        RUN: begin
          cnt_d = cnt_q - 1'b1;
          if ((full || last) && !(valid_q && !word_ready)) begin
            // partial final words are left-aligned with zero LSBs
            word_d  = pk_sh << (NW'(WORD_W) - pn_inc);
            valid_d = 1'b1;
            pk_d    = '0;
            pn_d    = '0;
            state_d = last ? FLUSH : RUN;
          end else begin
            pk_d    = pk_sh;
            pn_d    = pn_inc;
            state_d = (full || last) ? STALL : RUN;
          end
        end
        STALL:
          if (word_ready) begin
            word_d  = pk_q << (NW'(WORD_W) - pn_q);
            valid_d = 1'b1;
            pk_d    = '0;
            pn_d    = '0;
            state_d = (cnt_q == '0) ? FLUSH : RUN;
          end
        FLUSH:
          if (word_ready) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pk_q    <= '0;
      pn_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ld_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pk_q    <= pk_d;
      pn_q    <= pn_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ld_q    <= state_d == LOAD;
      en_q    <= state_d == LOAD || state_d == RUN;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
    end
  end
  assign lfsr_ld    = ld_q;
  assign lfsr_en    = en_q;
  assign word_data  = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule
